// File: rtl/imem_loader.sv
// imem_loader: byte-stream program loader for the instruction memory.
// It takes a framed stream (LEN_HI, LEN_LO, N big-endian words, optional CHK byte)
// and writes the words through the memory write port. The CPU is held in reset
// until a load completes successfully.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds the trailing XOR checksum
// byte and the CHECK state.
module imem_loader #(
  parameter int DEPTH = 64,
  parameter int AW    = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          byte_valid,
  input  logic [7:0]    byte_data,
  output logic          byte_ready,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [15:0]   wr_data,
  output logic          cpu_hold,
  output logic          done,
  output logic          error
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK, DONE, ERROR
  } state_t;
  localparam state_t FRAME_END = CHECK;
`else
  typedef enum logic [2:0] {
    IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, DONE, ERROR
  } state_t;
  localparam state_t FRAME_END = DONE;
`endif

  localparam logic [15:0] DEPTH_LIM = 16'(DEPTH);

  state_t        state;
  state_t        state_next;
  logic [7:0]    len_hi;
  logic [15:0]   len;
  logic [AW-1:0] idx;
  logic [7:0]    hi_byte;
  logic          xfer;
  logic          restart;
  logic [15:0]   len_word;
  logic          last_word;

  assign xfer      = byte_valid && byte_ready;
  assign restart   = start && (state == IDLE || state == DONE || state == ERROR);
  assign len_word  = {len_hi, byte_data};
  assign last_word = (32'(idx) + 32'd1) == 32'(len);

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] chk;

  // Running XOR of every frame byte up to the last data byte; cleared on a new load.
  always_ff @(posedge clk) begin
    if (reset) begin
      chk <= 8'h00;
    end else if (restart) begin
      chk <= 8'h00;
    end else if (xfer && state != CHECK) begin
      chk <= chk ^ byte_data;
    end
  end
`endif

  // State register; reset always wins over a same-cycle start.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode: advance one step per accepted byte, start only from a resting state.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE, ERROR: begin
        if (start) state_next = LEN_HI;
      end
      LEN_HI: begin
        if (xfer) state_next = LEN_LO;
      end
      LEN_LO: begin
        if (xfer) begin
          if (len_word > DEPTH_LIM)   state_next = ERROR;
          else if (len_word == 16'd0) state_next = FRAME_END;
          else                        state_next = DATA_HI;
        end
      end
      DATA_HI: begin
        if (xfer) state_next = DATA_LO;
      end
      DATA_LO: begin
        if (xfer) state_next = last_word ? FRAME_END : DATA_HI;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK: begin
        if (xfer) state_next = (byte_data == chk) ? DONE : ERROR;
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  // Frame datapath: latch length and high bytes, issue one registered write per word.
  always_ff @(posedge clk) begin
    if (reset) begin
      len_hi  <= 8'h00;
      len     <= 16'h0000;
      idx     <= '0;
      hi_byte <= 8'h00;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= 16'h0000;
    end else begin
      wr_en <= 1'b0;
      if (restart) begin
        idx <= '0;
      end
      if (xfer) begin
        case (state)
          LEN_HI:  len_hi  <= byte_data;
          LEN_LO:  len     <= len_word;
          DATA_HI: hi_byte <= byte_data;
          DATA_LO: begin
            wr_en   <= 1'b1;
            wr_addr <= idx;
            wr_data <= {hi_byte, byte_data};
            idx     <= idx + AW'(1);
          end
          default: ;
        endcase
      end
    end
  end

  // Status outputs decoded purely from state; done/error persist until the next start.
  always_comb begin
    byte_ready = 1'b0;
    case (state)
      LEN_HI, LEN_LO, DATA_HI, DATA_LO: byte_ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK: byte_ready = 1'b1;
`endif
      default: byte_ready = 1'b0;
    endcase
    cpu_hold = (state != DONE);
    done     = (state == DONE);
    error    = (state == ERROR);
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed self-checking bench for imem_loader.
// Works with or without IMEM_LOADER_CHECKSUM_EN defined.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [15:0] wr_data;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [15:0] log_addr[$];
  logic [15:0] log_data[$];
  int          log_cyc[$];
  logic [7:0]  frame[$];

  imem_loader #(.DEPTH(64), .AW(16)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .byte_valid(byte_valid),
    .byte_data(byte_data),
    .byte_ready(byte_ready),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .cpu_hold(cpu_hold),
    .done(done),
    .error(error)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Cycle counter used to measure write spacing.
  always @(posedge clk) cyc++;

  // Record every memory write mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      log_addr.push_back(wr_addr);
      log_data.push_back(wr_data);
      log_cyc.push_back(cyc);
    end
  end

  // Hard stop in case something wedges outside the bounded waits.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clearLog();
    log_addr.delete();
    log_data.delete();
    log_cyc.delete();
  endtask

  // Present one byte after 'gap' idle cycles and wait (bounded) for it to transfer.
  task automatic applyStimulus(input logic [7:0] b, input int gap);
    int waited;
    for (int g = 0; g < gap; g++) begin
      byte_valid = 1'b0;
      stepCycle();
    end
    byte_valid = 1'b1;
    byte_data  = b;
    waited     = 0;
    while (byte_ready !== 1'b1 && waited < 20) begin
      stepCycle();
      waited++;
    end
    if (waited >= 20) checkOutput("byte_ready_timeout", {31'd0, byte_ready}, 32'd1);
    else stepCycle();
  endtask

  // Stream the frame queue; optionally pulse start (valid low) after byte index inj.
  task automatic sendFrame(input int maxgap, input int inj);
    for (int i = 0; i < frame.size(); i++) begin
      applyStimulus(frame[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
      if (i == inj) begin
        byte_valid = 1'b0;
        start      = 1'b1;
        stepCycle();
        start      = 1'b0;
        checkOutput("start_ignored_ready", {31'd0, byte_ready}, 32'd1);
      end
    end
    byte_valid = 1'b0;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    stepCycle();
    start = 1'b0;
  endtask

  initial begin
    logic [15:0] w;
    logic [7:0]  sum;

    reset      = 1'b1;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    stepCycle();
    stepCycle();

    // Reset values.
    checkOutput("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
    checkOutput("rst_wr_en",      {31'd0, wr_en},      32'd0);
    checkOutput("rst_wr_addr",    {16'd0, wr_addr},    32'd0);
    checkOutput("rst_wr_data",    {16'd0, wr_data},    32'd0);
    checkOutput("rst_cpu_hold",   {31'd0, cpu_hold},   32'd1);
    checkOutput("rst_done",       {31'd0, done},       32'd0);
    checkOutput("rst_error",      {31'd0, error},      32'd0);

    // Start together with reset: reset wins, loader stays idle.
    start = 1'b1;
    stepCycle();
    start = 1'b0;
    reset = 1'b0;
    checkOutput("rst_start_idle", {31'd0, byte_ready}, 32'd0);
    stepCycle();
    checkOutput("idle_no_ready", {31'd0, byte_ready}, 32'd0);

    // Good three-word frame.
    $display("[TB] three-word load");
    clearLog();
    pulseStart();
    checkOutput("lenhi_ready", {31'd0, byte_ready}, 32'd1);
    frame = '{8'h00, 8'h03, 8'hC0, 8'h09, 8'h20, 8'h00, 8'hC0, 8'h04};
`ifdef IMEM_LOADER_CHECKSUM_EN
    frame.push_back(8'h2E);
`endif
    sendFrame(0, -1);
    checkOutput("t1_done",     {31'd0, done},       32'd1);
    checkOutput("t1_error",    {31'd0, error},      32'd0);
    checkOutput("t1_cpu_hold", {31'd0, cpu_hold},   32'd0);
    checkOutput("t1_ready",    {31'd0, byte_ready}, 32'd0);
`ifndef IMEM_LOADER_CHECKSUM_EN
    checkOutput("t1_last_wr_with_done", {31'd0, wr_en}, 32'd1);
`endif
    stepCycle();
    stepCycle();
    checkOutput("t1_nwrites", log_addr.size(), 32'd3);
    if (log_addr.size() == 3) begin
      checkOutput("t1_a0", {16'd0, log_addr[0]}, 32'd0);
      checkOutput("t1_d0", {16'd0, log_data[0]}, 32'hC009);
      checkOutput("t1_a1", {16'd0, log_addr[1]}, 32'd1);
      checkOutput("t1_d1", {16'd0, log_data[1]}, 32'h2000);
      checkOutput("t1_a2", {16'd0, log_addr[2]}, 32'd2);
      checkOutput("t1_d2", {16'd0, log_data[2]}, 32'hC004);
      checkOutput("t1_gap01", log_cyc[1] - log_cyc[0], 32'd2);
      checkOutput("t1_gap12", log_cyc[2] - log_cyc[1], 32'd2);
    end
    checkOutput("t1_hold_wr_en",   {31'd0, wr_en},   32'd0);
    checkOutput("t1_hold_wr_addr", {16'd0, wr_addr}, 32'd2);
    checkOutput("t1_hold_wr_data", {16'd0, wr_data}, 32'hC004);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Same frame with a bad checksum: words land, then error.
    $display("[TB] bad checksum");
    clearLog();
    pulseStart();
    checkOutput("t2_done_cleared", {31'd0, done}, 32'd0);
    frame = '{8'h00, 8'h03, 8'hC0, 8'h09, 8'h20, 8'h00, 8'hC0, 8'h04, 8'h2F};
    sendFrame(0, -1);
    checkOutput("t2_error",    {31'd0, error},    32'd1);
    checkOutput("t2_done",     {31'd0, done},     32'd0);
    checkOutput("t2_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    stepCycle();
    stepCycle();
    checkOutput("t2_nwrites", log_addr.size(), 32'd3);
`else
    // Bytes offered while DONE are not accepted.
    $display("[TB] bytes ignored in DONE");
    clearLog();
    byte_valid = 1'b1;
    byte_data  = 8'h55;
    stepCycle();
    stepCycle();
    stepCycle();
    byte_valid = 1'b0;
    checkOutput("t2_ready", {31'd0, byte_ready}, 32'd0);
    checkOutput("t2_done",  {31'd0, done},       32'd1);
    checkOutput("t2_nwrites", log_addr.size(), 32'd0);
`endif

    // Length above DEPTH.
    $display("[TB] oversize length");
    clearLog();
    pulseStart();
    checkOutput("t3_error_cleared", {31'd0, error}, 32'd0);
    frame = '{8'h00, 8'h41};
    sendFrame(0, -1);
    checkOutput("t3_error",    {31'd0, error},      32'd1);
    checkOutput("t3_done",     {31'd0, done},       32'd0);
    checkOutput("t3_cpu_hold", {31'd0, cpu_hold},   32'd1);
    checkOutput("t3_ready",    {31'd0, byte_ready}, 32'd0);
    checkOutput("t3_wr_en",    {31'd0, wr_en},      32'd0);
    stepCycle();
    stepCycle();
    checkOutput("t3_nwrites", log_addr.size(), 32'd0);

    // Zero-length frame.
    $display("[TB] zero length");
    clearLog();
    pulseStart();
    frame = '{8'h00, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
    frame.push_back(8'h00);
`endif
    sendFrame(0, -1);
    checkOutput("t4_done",     {31'd0, done},     32'd1);
    checkOutput("t4_error",    {31'd0, error},    32'd0);
    checkOutput("t4_cpu_hold", {31'd0, cpu_hold}, 32'd0);
    stepCycle();
    checkOutput("t4_nwrites", log_addr.size(), 32'd0);

    // Thirteen words with random valid gaps and a stray start mid-frame.
    $display("[TB] 13-word load with gaps");
    clearLog();
    pulseStart();
    frame = '{8'h00, 8'h0D};
    sum   = 8'h0D;
    for (int i = 0; i < 13; i++) begin
      w = 16'hA050 + 16'(i) * 16'h0713;
      frame.push_back(w[15:8]);
      frame.push_back(w[7:0]);
      sum = sum ^ w[15:8] ^ w[7:0];
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    frame.push_back(sum);
`endif
    sendFrame(2, 10);
    checkOutput("t5_done", {31'd0, done}, 32'd1);
    stepCycle();
    stepCycle();
    checkOutput("t5_nwrites", log_addr.size(), 32'd13);
    if (log_addr.size() == 13) begin
      for (int i = 0; i < 13; i++) begin
        w = 16'hA050 + 16'(i) * 16'h0713;
        checkOutput($sformatf("t5_a%0d", i), {16'd0, log_addr[i]}, 32'(i));
        checkOutput($sformatf("t5_d%0d", i), {16'd0, log_data[i]}, {16'd0, w});
      end
    end

    // Reset in the middle of word 2, then a fresh load.
    $display("[TB] reset mid-load");
    clearLog();
    pulseStart();
    frame = '{8'h00, 8'h05, 8'h11, 8'h11, 8'h22, 8'h22, 8'h33};
    sendFrame(0, -1);
    reset = 1'b1;
    stepCycle();
    reset = 1'b0;
    checkOutput("t6_ready",    {31'd0, byte_ready}, 32'd0);
    checkOutput("t6_cpu_hold", {31'd0, cpu_hold},   32'd1);
    checkOutput("t6_done",     {31'd0, done},       32'd0);
    checkOutput("t6_error",    {31'd0, error},      32'd0);
    checkOutput("t6_wr_en",    {31'd0, wr_en},      32'd0);
    stepCycle();
    stepCycle();
    checkOutput("t6_nwrites", log_addr.size(), 32'd2);
    if (log_addr.size() == 2) begin
      checkOutput("t6_a1", {16'd0, log_addr[1]}, 32'd1);
      checkOutput("t6_d1", {16'd0, log_data[1]}, 32'h2222);
    end
    clearLog();
    pulseStart();
    frame = '{8'h00, 8'h02, 8'hAB, 8'hCD, 8'h12, 8'h34};
`ifdef IMEM_LOADER_CHECKSUM_EN
    frame.push_back(8'h42);
`endif
    sendFrame(0, -1);
    checkOutput("t6_reload_done", {31'd0, done}, 32'd1);
    stepCycle();
    stepCycle();
    checkOutput("t6_reload_nwrites", log_addr.size(), 32'd2);
    if (log_addr.size() == 2) begin
      checkOutput("t6_r_a0", {16'd0, log_addr[0]}, 32'd0);
      checkOutput("t6_r_d0", {16'd0, log_data[0]}, 32'hABCD);
      checkOutput("t6_r_a1", {16'd0, log_addr[1]}, 32'd1);
      checkOutput("t6_r_d1", {16'd0, log_data[1]}, 32'h1234);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Byte-stream program loader that writes 16-bit instruction words into the instruction memory before the CPU runs. It accepts a framed byte stream over a valid/ready handshake and assembles big-endian words. It drives the instruction memory write port (word address, data, enable) and holds the CPU in reset until a load completes. It is the write-side counterpart of the instruction memory's combinational read port.

## Interface
- DEPTH, 64, number of instruction words in the memory; a length above DEPTH is an error
- AW, 16, width of the word address driven to the memory
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERROR
- byte_valid  in  1  byte_data is presented
- byte_data  in  8  stream byte
- byte_ready  out  1  loader accepts a byte this cycle; a byte transfers on a clk edge with byte_valid && byte_ready
- wr_en  out  1  one-cycle instruction-memory write strobe
- wr_addr  out  AW  word address, 0-based
- wr_data  out  16  assembled instruction word
- cpu_hold  out  1  high while the CPU must stay in reset
- done  out  1  load finished successfully; sticky
- error  out  1  load aborted; sticky

## Operation
- Frame after start: LEN_HI, LEN_LO (word count N, 16-bit), then N words as hi byte then lo byte, then one CHK byte (with checksum enabled).
- States: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK, DONE, ERROR.
- IDLE/DONE/ERROR + start -> LEN_HI. On entry, clear done, error, the word index, and the running checksum.
- LEN_HI -> LEN_LO on transfer; high byte is latched.
- LEN_LO on transfer:
  - N > DEPTH -> ERROR.
  - N == 0 -> CHECK (or DONE if checksum compiled out).
  - Otherwise -> DATA_HI.
- DATA_HI -> DATA_LO on transfer; high byte is latched.
- DATA_LO on transfer:
  - Issue a write of {hi, lo} at the current index, then increment the index.
  - If the index reaches N -> CHECK (or DONE); otherwise -> DATA_HI.
- Running checksum: XOR of every byte from LEN_HI through the last DATA_LO byte.
- CHECK on transfer: byte equal to the checksum -> DONE, otherwise -> ERROR.
- byte_ready is high exactly in LEN_HI, LEN_LO, DATA_HI, DATA_LO and CHECK. It is decoded from state, with no dependence on byte_valid.
- cpu_hold:
  - High from reset and in all states except DONE.
  - An ERROR leaves the CPU held.
- start in any loading state is ignored; byte_valid in IDLE/DONE/ERROR is ignored (no transfer).
- Words already written before an ERROR stay in memory; they are not rolled back.
- The word index is AW bits and never wraps, since N <= DEPTH.

## Timing
- Reset values: byte_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_hold=1, done=0, error=0, state=IDLE.
- Throughput: one byte per cycle while byte_valid stays high; one word every 2 cycles.
- wr_en, wr_addr and wr_data are registered. They are valid for exactly the one cycle after the DATA_LO transfer edge.
- wr_addr and wr_data hold their last value while wr_en is low.
- done/error assert in the cycle after the final transfer edge (the CHK byte, the LEN_LO error, or the last DATA_LO when checksum is compiled out). cpu_hold deasserts in that same cycle on success.
- The final word's wr_en and done coincide when checksum is compiled out.
- reset asserted mid-load returns to IDLE at that edge. wr_en is low the following cycle and no partial word is written.
- start and a reset in the same cycle: reset wins.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined: CHECK state present; frame ends with the CHK byte; a mismatch -> ERROR.
- IMEM_LOADER_CHECKSUM_EN undefined:
  - CHECK state and checksum register are removed.
  - The last DATA_LO transfer (or LEN_LO with N=0) -> DONE.
  - error asserts only for N > DEPTH.

## Test plan
- start, then stream 00 03 C0 09 20 00 C0 04 chk=0x2E with valid held high -> writes (0,C009),(1,2000),(2,C004) on consecutive odd cycles. done=1 and cpu_hold=0 one cycle after CHK; error=0.
- Same frame with chk=0x2F -> three writes occur, error=1, done=0, cpu_hold stays 1.
- start, 00 41 (N=65 > DEPTH=64) -> error=1 one cycle after LEN_LO, no wr_en, byte_ready=0 afterwards.
- start, 00 00 00 -> no writes, done=1 (checksum 0 matches). With macro undefined, done=1 after the LEN_LO byte.
- Toggle byte_valid randomly and pulse start mid-frame during a 13-word load -> the start pulse is ignored. Writes go to addresses 0..12 in order with correct data, and no transfer occurs while byte_valid=0.
- Assert reset after the DATA_HI byte of word 2 -> state IDLE, cpu_hold=1, done=0. No write at address 2; a new start/frame then loads correctly from address 0.
